snake_stream: RTL and testbench

- Owns the snake body state: head coordinate, segment length, and a per-segment link-direction list.
- On each replay request it streams every segment, head to tail, one segment per clock to the VGA renderer: snake_x/y, snake_dir, snake_first, snake_last, snake_valid.
- Applies game moves (step/grow) between replays.
- Produces self-collision and apple-overlap results as a side product of each replay.

---
 rtl/snake_stream_if.sv | 39 +++
 rtl/snake_stream.sv | 196 +++++++++++++++++++
 tb/tb_snake_stream.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_stream_if.sv
// Bundles the game-side and renderer-side signals of snake_stream.
// slave is the snake_stream side; master is the game/renderer side.
interface snake_stream_if;
  logic       start;
  logic       step;
  logic [1:0] step_dir;
  logic       grow;
  logic [4:0] apple_x;
  logic [3:0] apple_y;
  logic       step_ready;
  logic       busy;
  logic [4:0] snake_x;
  logic [3:0] snake_y;
  logic [1:0] snake_dir;
  logic       snake_first;
  logic       snake_last;
  logic       snake_valid;
  logic [4:0] snake_head_x;
  logic [3:0] snake_head_y;
  logic [5:0] length;
  logic       done;
  logic       self_hit;
  logic       apple_hit;
  logic       wall_hit;

  modport slave (
    input  start, step, step_dir, grow, apple_x, apple_y,
    output step_ready, busy, snake_x, snake_y, snake_dir, snake_first,
           snake_last, snake_valid, snake_head_x, snake_head_y, length,
           done, self_hit, apple_hit, wall_hit
  );

  modport master (
    output start, step, step_dir, grow, apple_x, apple_y,
    input  step_ready, busy, snake_x, snake_y, snake_dir, snake_first,
           snake_last, snake_valid, snake_head_x, snake_head_y, length,
           done, self_hit, apple_hit, wall_hit
  );
endinterface

// File: rtl/snake_stream.sv
// Snake body store: head plus a link-direction list, streamed head-to-tail on request.
// Collision and apple results are gathered while the body is streamed.
module snake_stream #(
  parameter int GAME_WIDTH  = 18,
  parameter int GAME_HEIGHT = 13,
  parameter int MAX_LEN     = 32,
  parameter int START_X     = 4,
  parameter int START_Y     = 7,
  parameter int START_LEN   = 3
) (
  input  logic clk,
  input  logic rst,
  snake_stream_if.slave bus
);

  localparam int IW = $clog2(MAX_LEN);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e        state_q;
  logic [IW-1:0] idx_q;
  logic [4:0]    cx_q, hx_q, hx_d;
  logic [3:0]    cy_q, hy_q, hy_d;
  logic [5:0]    len_q, len_d;
  logic [1:0]    link_q [MAX_LEN];
  logic [1:0]    link_d [MAX_LEN];
  logic          pend_q, pend_grow_q;
  logic [1:0]    pend_dir_q;
  logic          self_acc_q, apple_acc_q;
  logic          valid_q, first_q, last_q, done_q, self_hit_q, apple_hit_q;
  logic [4:0]    x_q;
  logic [3:0]    y_q;
  logic [1:0]    dir_q;

  logic          do_move, mv_grow;
  logic [1:0]    mv_dir, seg_dir;
  logic [IW-1:0] ei;
  logic [4:0]    ex, nx;
  logic [3:0]    ey, ny;
  logic          is_last, self_now, apple_now;

  function automatic logic [4:0] stepX(input logic [4:0] x, input logic [1:0] d);
    case (d)
      2'd2:    return x - 5'd1;
      2'd3:    return x + 5'd1;
      default: return x;
    endcase
  endfunction

  function automatic logic [3:0] stepY(input logic [3:0] y, input logic [1:0] d);
    case (d)
      2'd0:    return y - 4'd1;
      2'd1:    return y + 4'd1;
      default: return y;
    endcase
  endfunction

  // A pending move outranks both a fresh step and a start request.
  always_comb begin
    do_move = (state_q == IDLE) && (pend_q || bus.step);
    mv_dir  = pend_q ? pend_dir_q  : bus.step_dir;
    mv_grow = pend_q ? pend_grow_q : bus.grow;
    hx_d    = hx_q;
    hy_d    = hy_q;
    len_d   = len_q;
    link_d  = link_q;
    if (do_move) begin
      hx_d = stepX(hx_q, mv_dir);
      hy_d = stepY(hy_q, mv_dir);
      for (int i = 1; i < MAX_LEN; i++) link_d[i] = link_q[i-1];
      link_d[0] = {mv_dir[1], ~mv_dir[0]};
      if (mv_grow && (len_q < 6'(MAX_LEN))) len_d = len_q + 6'd1;
    end
  end

  // Segment being emitted this edge: the (possibly just moved) head on start, else the cursor.
  always_comb begin
    if (state_q == IDLE) begin
      ei = '0;
      ex = hx_d;
      ey = hy_d;
    end else begin
      ei = idx_q;
      ex = cx_q;
      ey = cy_q;
    end
    seg_dir   = link_d[ei];
    nx        = stepX(ex, seg_dir);
    ny        = stepY(ey, seg_dir);
    is_last   = (6'(ei) == len_d - 6'd1);
    self_now  = (ei != '0) && (ex == hx_q) && (ey == hy_q);
    apple_now = (ex == bus.apple_x) && (ey == bus.apple_y);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      hx_q        <= 5'(START_X);
      hy_q        <= 4'(START_Y);
      len_q       <= 6'(START_LEN);
      for (int i = 0; i < MAX_LEN; i++) link_q[i] <= 2'd2;
      pend_q      <= 1'b0;
      pend_dir_q  <= 2'd0;
      pend_grow_q <= 1'b0;
      self_acc_q  <= 1'b0;
      apple_acc_q <= 1'b0;
      valid_q     <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      self_hit_q  <= 1'b0;
      apple_hit_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      dir_q       <= '0;
    end else begin
      hx_q   <= hx_d;
      hy_q   <= hy_d;
      len_q  <= len_d;
      link_q <= link_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            pend_q <= 1'b0;
          end else if (bus.start) begin
            state_q     <= STREAM;
            valid_q     <= 1'b1;
            x_q         <= ex;
            y_q         <= ey;
            dir_q       <= seg_dir;
            first_q     <= 1'b1;
            last_q      <= is_last;
            cx_q        <= nx;
            cy_q        <= ny;
            idx_q       <= ei + IW'(1);
            self_acc_q  <= 1'b0;
            apple_acc_q <= apple_now;
          end
        end
        STREAM: begin
          if (bus.step && !pend_q) begin
            pend_q      <= 1'b1;
            pend_dir_q  <= bus.step_dir;
            pend_grow_q <= bus.grow;
          end
          if (last_q) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            dir_q       <= '0;
            done_q      <= 1'b1;
            self_hit_q  <= self_acc_q;
            apple_hit_q <= apple_acc_q;
          end else begin
            x_q         <= ex;
            y_q         <= ey;
            dir_q       <= seg_dir;
            first_q     <= 1'b0;
            last_q      <= is_last;
            cx_q        <= nx;
            cy_q        <= ny;
            idx_q       <= ei + IW'(1);
            self_acc_q  <= self_acc_q | self_now;
            apple_acc_q <= apple_acc_q | apple_now;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.step_ready   = ~pend_q;
  assign bus.busy         = (state_q == STREAM);
  assign bus.snake_x      = x_q;
  assign bus.snake_y      = y_q;
  assign bus.snake_dir    = dir_q;
  assign bus.snake_first  = first_q;
  assign bus.snake_last   = last_q;
  assign bus.snake_valid  = valid_q;
  assign bus.snake_head_x = hx_q;
  assign bus.snake_head_y = hy_q;
  assign bus.length       = len_q;
  assign bus.done         = done_q;
  assign bus.self_hit     = self_hit_q;
  assign bus.apple_hit    = apple_hit_q;
  assign bus.wall_hit     = (hx_q == 5'd0) || (hx_q == 5'(GAME_WIDTH + 1)) ||
                            (hy_q == 4'd0) || (hy_q == 4'(GAME_HEIGHT + 1));

endmodule

// File: tb/tb_snake_stream.sv
// Bench for snake_stream: the snake is modelled as a list of tile positions, head first.
// Directed scenarios run first, then a randomized walk with replays.
module tb_snake_stream;
  localparam int GAME_WIDTH  = 18;
  localparam int GAME_HEIGHT = 13;
  localparam int MAX_LEN     = 32;
  localparam int START_X     = 4;
  localparam int START_Y     = 7;
  localparam int START_LEN   = 3;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  // Tile positions of every link slot; entry MAX_LEN is needed to derive the last link.
  logic [4:0] mx [0:MAX_LEN];
  logic [3:0] my [0:MAX_LEN];
  int         mlen;

  snake_stream_if bus ();

  snake_stream #(
    .GAME_WIDTH (GAME_WIDTH),
    .GAME_HEIGHT(GAME_HEIGHT),
    .MAX_LEN    (MAX_LEN),
    .START_X    (START_X),
    .START_Y    (START_Y),
    .START_LEN  (START_LEN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i <= MAX_LEN; i++) begin
      mx[i] = 5'(START_X - i);
      my[i] = 4'(START_Y);
    end
    mlen = START_LEN;
  endfunction

  function automatic void modelMove(input logic [1:0] d, input bit g);
    for (int i = MAX_LEN; i >= 1; i--) begin
      mx[i] = mx[i-1];
      my[i] = my[i-1];
    end
    case (d)
      2'd0: my[0] = my[0] - 4'd1;
      2'd1: my[0] = my[0] + 4'd1;
      2'd2: mx[0] = mx[0] - 5'd1;
      default: mx[0] = mx[0] + 5'd1;
    endcase
    if (g && mlen < MAX_LEN) mlen++;
  endfunction

  function automatic logic [1:0] dirOf(input int i);
    logic [4:0] dx;
    logic [3:0] dy;
    dx = mx[i+1] - mx[i];
    dy = my[i+1] - my[i];
    if (dx == 5'd1)  return 2'd3;
    if (dx == 5'd31) return 2'd2;
    if (dy == 4'd1)  return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit modelWall();
    return (mx[0] == 5'd0) || (mx[0] == 5'(GAME_WIDTH + 1)) ||
           (my[0] == 4'd0) || (my[0] == 4'(GAME_HEIGHT + 1));
  endfunction

  task automatic checkHead(input string tag);
    checkOutput({tag, ".head_x"}, 32'(bus.snake_head_x), 32'(mx[0]));
    checkOutput({tag, ".head_y"}, 32'(bus.snake_head_y), 32'(my[0]));
    checkOutput({tag, ".length"}, 32'(bus.length), 32'(mlen));
    checkOutput({tag, ".wall"},   32'(bus.wall_hit), 32'(modelWall()));
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.step = 1'b0;
    bus.grow = 1'b0;
    bus.step_dir = 2'd0;
    tick();
    tick();
    rst = 1'b0;
    modelReset();
  endtask

  // One move in IDLE; it takes effect at the very next edge.
  task automatic applyStimulus(input logic [1:0] d, input bit g);
    bus.step = 1'b1;
    bus.step_dir = d;
    bus.grow = g;
    tick();
    bus.step = 1'b0;
    bus.grow = 1'b0;
    modelMove(d, g);
    checkHead("move");
  endtask

  // Full replay; optionally a step alongside start, and/or steps injected mid-stream.
  task automatic runReplay(input bit withStep, input bit startStep, input logic [1:0] sdir, input bit sgrow);
    bit pend;
    int n;
    bit expSelf, expApple;
    pend = 1'b0;
    bus.start = 1'b1;
    if (startStep) begin
      bus.step = 1'b1;
      bus.step_dir = sdir;
      bus.grow = sgrow;
    end
    tick();
    bus.start = 1'b0;
    bus.step = 1'b0;
    bus.grow = 1'b0;
    if (startStep) modelMove(sdir, sgrow);
    n = mlen;
    expSelf = 1'b0;
    expApple = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i > 0 && mx[i] == mx[0] && my[i] == my[0]) expSelf = 1'b1;
      if (mx[i] == bus.apple_x && my[i] == bus.apple_y) expApple = 1'b1;
    end
    for (int k = 0; k < n; k++) begin
      checkOutput("seg.valid", 32'(bus.snake_valid), 32'd1);
      checkOutput("seg.busy",  32'(bus.busy), 32'd1);
      checkOutput("seg.x",     32'(bus.snake_x), 32'(mx[k]));
      checkOutput("seg.y",     32'(bus.snake_y), 32'(my[k]));
      checkOutput("seg.dir",   32'(bus.snake_dir), 32'(dirOf(k)));
      checkOutput("seg.first", 32'(bus.snake_first), 32'(k == 0));
      checkOutput("seg.last",  32'(bus.snake_last), 32'(k == n - 1));
      checkOutput("seg.done",  32'(bus.done), 32'd0);
      checkOutput("seg.headx", 32'(bus.snake_head_x), 32'(mx[0]));
      if (withStep && k >= 2) checkOutput("seg.step_ready", 32'(bus.step_ready), 32'd0);
      bus.step = 1'b0;
      bus.grow = 1'b0;
      if (withStep && k == 1) begin
        bus.step = 1'b1;
        bus.step_dir = 2'd0;
        bus.grow = 1'b1;
        pend = 1'b1;
      end else if (withStep && k == 2) begin
        bus.step = 1'b1;
        bus.step_dir = 2'd1;
      end
      tick();
    end
    bus.step = 1'b0;
    bus.grow = 1'b0;
    checkOutput("done.pulse", 32'(bus.done), 32'd1);
    checkOutput("done.valid", 32'(bus.snake_valid), 32'd0);
    checkOutput("done.busy",  32'(bus.busy), 32'd0);
    checkOutput("done.self",  32'(bus.self_hit), 32'(expSelf));
    checkOutput("done.apple", 32'(bus.apple_hit), 32'(expApple));
    tick();
    checkOutput("post.done", 32'(bus.done), 32'd0);
    if (pend) modelMove(2'd0, 1'b1);
    checkOutput("post.step_ready", 32'(bus.step_ready), 32'd1);
    checkHead("post");
  endtask

  initial begin
    bus.apple_x = 5'd9;
    bus.apple_y = 4'd9;
    doReset();

    $display("[TB] reset state");
    checkOutput("rst.step_ready", 32'(bus.step_ready), 32'd1);
    checkOutput("rst.busy",       32'(bus.busy), 32'd0);
    checkOutput("rst.valid",      32'(bus.snake_valid), 32'd0);
    checkOutput("rst.done",       32'(bus.done), 32'd0);
    checkOutput("rst.self",       32'(bus.self_hit), 32'd0);
    checkOutput("rst.apple",      32'(bus.apple_hit), 32'd0);
    checkOutput("rst.head_x",     32'(bus.snake_head_x), 32'd4);
    checkOutput("rst.head_y",     32'(bus.snake_head_y), 32'd7);
    checkOutput("rst.length",     32'(bus.length), 32'd3);
    checkOutput("rst.wall",       32'(bus.wall_hit), 32'd0);

    $display("[TB] apple on body, then off body");
    bus.apple_x = 5'd3;
    bus.apple_y = 4'd7;
    runReplay(1'b0, 1'b0, 2'd0, 1'b0);
    bus.apple_x = 5'd9;
    bus.apple_y = 4'd9;
    runReplay(1'b0, 1'b0, 2'd0, 1'b0);

    $display("[TB] grow right, then self collision loop");
    applyStimulus(2'd3, 1'b1);
    runReplay(1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(2'd3, 1'b1);
    applyStimulus(2'd0, 1'b1);
    applyStimulus(2'd2, 1'b1);
    applyStimulus(2'd1, 1'b1);
    runReplay(1'b0, 1'b0, 2'd0, 1'b0);

    $display("[TB] steps during stream");
    doReset();
    runReplay(1'b1, 1'b0, 2'd0, 1'b0);

    $display("[TB] start together with step");
    runReplay(1'b0, 1'b1, 2'd3, 1'b1);

    $display("[TB] wall at left border");
    doReset();
    applyStimulus(2'd2, 1'b0);
    applyStimulus(2'd2, 1'b0);
    applyStimulus(2'd2, 1'b0);
    applyStimulus(2'd2, 1'b0);
    runReplay(1'b0, 1'b0, 2'd0, 1'b0);

    $display("[TB] reset mid-stream");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    modelReset();
    checkOutput("midrst.valid", 32'(bus.snake_valid), 32'd0);
    checkOutput("midrst.busy",  32'(bus.busy), 32'd0);
    checkOutput("midrst.done",  32'(bus.done), 32'd0);
    checkHead("midrst");
    tick();
    checkOutput("midrst.done2",  32'(bus.done), 32'd0);
    checkOutput("midrst.valid2", 32'(bus.snake_valid), 32'd0);

    $display("[TB] length saturation");
    for (int i = 0; i < MAX_LEN + 3; i++) applyStimulus(2'(i % 2 == 0 ? 3 : 1), 1'b1);
    checkOutput("sat.length", 32'(bus.length), 32'(MAX_LEN));
    runReplay(1'b0, 1'b0, 2'd0, 1'b0);

    $display("[TB] randomized walk");
    doReset();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          int j;
          j = $urandom_range(0, mlen - 1);
          bus.apple_x = mx[j];
          bus.apple_y = my[j];
        end else begin
          bus.apple_x = 5'($urandom_range(0, 31));
          bus.apple_y = 4'($urandom_range(0, 15));
        end
        runReplay(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
